mul_accumulator: RTL

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

---
 rtl/mul_accumulator.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mul_accumulator.sv
// mul_accumulator: saturating accumulator for the products of a 32x32 signed
// multiplier. It sums a group of 64-bit products, and in_last marks the final
// term of each group. The group result is then held until the consumer takes it.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    upstream product available
//   in_ready    block accepts in_product this cycle
//   in_product  signed 64-bit product
//   in_last     in_product is the final term of the group
//   acc_clr     discard the partial group (ignored while a result is held)
//   out_valid   group result held on out_sum/out_count/out_ovf
//   out_ready   downstream consumes the result
//   out_sum     signed saturated group sum
//   out_count   number of accepted products, saturating at 0xFFFF
//   out_ovf     sticky: saturation occurred at least once in the group
module mul_accumulator (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_product,
   input  logic        in_last,
   input  logic        acc_clr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_sum,
   output logic [15:0] out_count,
   output logic        out_ovf
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   localparam logic [63:0] SUM_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SUM_MIN = 64'h8000_0000_0000_0000;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   state_e      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ovf_q, ovf_d;

   logic        in_xfer;
   logic        out_xfer;
   logic [64:0] sum_wide;
   logic        sat_hit;
   logic [63:0] sat_sum;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // Add at 65 bits. The sum has left the 64-bit range exactly when the two
   // top bits differ, and bit 64 then gives the true sign of the result.
   assign sum_wide = {acc_q[63], acc_q} + {in_product[63], in_product};
   assign sat_hit  = sum_wide[64] ^ sum_wide[63];
   assign sat_sum  = sat_hit ? (sum_wide[64] ? SUM_MIN : SUM_MAX) : sum_wide[63:0];

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state is written with non-blocking (<=) assignments only,
   // so every register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM: if (in_xfer && in_last) state_d = HOLD;
         HOLD:  if (out_xfer)           state_d = ACCUM;
         default:                       state_d = ACCUM;
      endcase
   end

   // ---------------- FSM: output logic ----------------
   // acc_clr drops in_ready so that no product is taken in the cycle the
   // group is discarded.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ACCUM:   in_ready  = !acc_clr;
         HOLD:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (state_q == ACCUM) begin
         if (acc_clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
         end else if (in_xfer) begin
            acc_d = sat_sum;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
            ovf_d = ovf_q | sat_hit;
         end
      end else if (out_xfer) begin
         // Clearing on the same edge as the hand-off lets the next group start
         // on the following cycle.
         acc_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end
   end

   // NOTE: the data registers take the synchronous reset too. Reset has to
   // throw away a partial group or a pending result, not only restart the FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // The result ports show the live accumulator at all times. They are
   // meaningful only while out_valid is high.
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule
